// File: rtl/collision_pkg.sv
// Shared constants and types for the collision pipeline front end.
// Widths, FP32 field constants and the dist_sq_to_float FSM state encoding.
package collision_pkg;

  localparam int COORD_W  = 16;
  localparam int SUM_W    = 2 * COORD_W + 2;

  localparam int FP_BIAS  = 127;
  localparam int FP_MAN_W = 23;
  localparam int FP_EXP_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIFF,
    ST_MAC0,
    ST_MAC1,
    ST_MAC2,
    ST_CONV,
    ST_DONE
  } state_e;

endpackage

// File: rtl/uint_to_fp32.sv
// Combinational unsigned integer to IEEE-754 single conversion (leading-one detect, normalise, pack).
// Rounding is truncation unless DIST_SQ_ROUND_NEAREST_EN selects round-to-nearest-even.
module uint_to_fp32 #(
  parameter int IN_W = collision_pkg::SUM_W
) (
  input  logic [IN_W-1:0] val,
  output logic [31:0]     fp
);
  import collision_pkg::*;

  localparam int PW   = $clog2(IN_W);
  localparam int DROP = IN_W - 1 - FP_MAN_W;

  logic [PW-1:0]       msb;
  logic [IN_W-1:0]     norm;
  logic [FP_MAN_W-1:0] man;
  logic [FP_MAN_W:0]   man_r;
  logic [FP_EXP_W-1:0] exp_f;
  logic                unused_bits;

`ifdef DIST_SQ_ROUND_NEAREST_EN
  function automatic logic [FP_MAN_W:0] round_rne(input logic [FP_MAN_W-1:0] m,
                                                  input logic guard, input logic sticky);
    round_rne = {1'b0, m} + {{FP_MAN_W{1'b0}}, guard & (sticky | m[0])};
  endfunction
`endif

  always_comb begin
    msb = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (val[i]) msb = PW'(i);
    end
  end

  // Move the leading one to the top bit; the mantissa is the field just below it.
  assign norm = val << (PW'(IN_W - 1) - msb);
  assign man  = norm[IN_W-2 -: FP_MAN_W];

`ifdef DIST_SQ_ROUND_NEAREST_EN
  assign man_r = round_rne(man, norm[DROP-1], |norm[DROP-2:0]);
`else
  assign man_r = {1'b0, man};
`endif

  assign unused_bits = ^{norm[IN_W-1], norm[DROP-1:0]};

  // A rounding carry-out leaves man_r[22:0] zero and bumps the exponent.
  assign exp_f = FP_EXP_W'(FP_BIAS) + FP_EXP_W'(msb) + FP_EXP_W'(man_r[FP_MAN_W]);

  always_comb begin
    fp = 32'h0;
    if (val != '0) fp = {1'b0, exp_f, man_r[FP_MAN_W-1:0]};
  end

endmodule

// File: rtl/dist_sq_to_float.sv
// Squared Euclidean distance of two signed 3-D points, converted to FP32 for the sqrt stage.
// One shared multiplier over three MAC cycles; DIST_SQ_ROUND_NEAREST_EN enables RNE conversion.
module dist_sq_to_float #(
  parameter int COORD_W = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COORD_W-1:0] ax,
  input  logic signed [COORD_W-1:0] ay,
  input  logic signed [COORD_W-1:0] az,
  input  logic signed [COORD_W-1:0] bx,
  input  logic signed [COORD_W-1:0] by,
  input  logic signed [COORD_W-1:0] bz,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               res
);
  localparam int SUM_W  = 2 * COORD_W + 2;
  localparam int DIFF_W = COORD_W + 1;

  import collision_pkg::*;

  state_e state_q, state_d;

  logic signed [COORD_W-1:0] ax_q, ay_q, az_q, bx_q, by_q, bz_q;
  logic signed [COORD_W-1:0] ax_d, ay_d, az_d, bx_d, by_d, bz_d;
  logic signed [DIFF_W-1:0]  dx_q, dy_q, dz_q, dx_d, dy_d, dz_d;
  logic [SUM_W-1:0]          acc_q, acc_d;
  logic [31:0]               res_q, res_d;

  logic                      capture;
  logic signed [DIFF_W-1:0]  mul_op;
  logic signed [2*DIFF_W-1:0] prod;
  logic [SUM_W-2:0]          sq;
  logic                      unused_sign;
  logic [31:0]               fp;

  // Control and result registers; abandoned work never reaches res.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      res_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  // Operand registers carry no reset: they are only consumed after a fresh capture.
  always_ff @(posedge CLK) begin
    ax_q <= ax_d;
    ay_q <= ay_d;
    az_q <= az_d;
    bx_q <= bx_d;
    by_q <= by_d;
    bz_q <= bz_d;
    dx_q <= dx_d;
    dy_q <= dy_d;
    dz_q <= dz_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_DIFF;
      ST_DIFF: state_d = ST_MAC0;
      ST_MAC0: state_d = ST_MAC1;
      ST_MAC1: state_d = ST_MAC2;
      ST_MAC2: state_d = ST_CONV;
      ST_CONV: state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  always_comb begin
    capture = (state_q == ST_IDLE) && in_valid;
    ax_d = capture ? ax : ax_q;
    ay_d = capture ? ay : ay_q;
    az_d = capture ? az : az_q;
    bx_d = capture ? bx : bx_q;
    by_d = capture ? by : by_q;
    bz_d = capture ? bz : bz_q;

    dx_d = dx_q;
    dy_d = dy_q;
    dz_d = dz_q;
    if (state_q == ST_DIFF) begin
      dx_d = {bx_q[COORD_W-1], bx_q} - {ax_q[COORD_W-1], ax_q};
      dy_d = {by_q[COORD_W-1], by_q} - {ay_q[COORD_W-1], ay_q};
      dz_d = {bz_q[COORD_W-1], bz_q} - {az_q[COORD_W-1], az_q};
    end
  end

  // Shared squarer: one difference per MAC cycle; a square never exceeds 33 bits.
  always_comb begin
    mul_op = '0;
    unique case (state_q)
      ST_MAC0: mul_op = dx_q;
      ST_MAC1: mul_op = dy_q;
      ST_MAC2: mul_op = dz_q;
      default: mul_op = '0;
    endcase
  end

  assign prod        = mul_op * mul_op;
  assign sq          = prod[SUM_W-2:0];
  assign unused_sign = prod[2*DIFF_W-1];

  always_comb begin
    acc_d = acc_q;
    unique case (state_q)
      ST_MAC0: acc_d = {1'b0, sq};
      ST_MAC1,
      ST_MAC2: acc_d = acc_q + {1'b0, sq};
      default: acc_d = acc_q;
    endcase
  end

  uint_to_fp32 #(.IN_W(SUM_W)) u_conv (
    .val (acc_q),
    .fp  (fp)
  );

  always_comb begin
    res_d = res_q;
    if (state_q == ST_CONV) res_d = fp;
  end

  assign res = res_q;

endmodule
